// File: rtl/bus_if_pkg.sv
// rtl/bus_if_pkg.sv - shared sequencer encoding and width helper for buffered_bus_interface
package bus_if_pkg;

    localparam logic [1:0] SEQ_IDLE      = 2'd0;
    localparam logic [1:0] SEQ_START     = 2'd1;
    localparam logic [1:0] SEQ_WAIT_DONE = 2'd2;

    // Ceiling log2, elaboration-time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// rtl/bus_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
module bus_sync_fifo
    import bus_if_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [clog2(DEPTH):0]   count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so an empty FIFO presents zero instead of stale data.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/buffered_bus_interface.sv
// rtl/buffered_bus_interface.sv - per-channel RX/TX buffering and send sequencing for the bus controller
module buffered_bus_interface
    import bus_if_pkg::*;
#(
    parameter int NUM_IFS       = 2,
    parameter int NUM_DATA_BITS = 8,
    parameter int RX_DEPTH      = 4,
    parameter int TX_DEPTH      = 4,
    parameter int DONE_TIMEOUT  = 0
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic [NUM_IFS-1:0]                 ctrl_recv_new_data,
    input  logic [NUM_IFS*NUM_DATA_BITS-1:0]   ctrl_recv_data,
    input  logic [NUM_IFS-1:0]                 ctrl_send_ready,
    input  logic [NUM_IFS-1:0]                 ctrl_send_done,
    output logic [NUM_IFS-1:0]                 ctrl_send_start,
    output logic [NUM_IFS-1:0]                 ctrl_select,
    output logic [NUM_IFS-1:0]                 ctrl_keep_alive,
    output logic [NUM_IFS*NUM_DATA_BITS-1:0]   ctrl_send_data,
    output logic [NUM_IFS-1:0]                 rx_valid,
    input  logic [NUM_IFS-1:0]                 rx_ready,
    output logic [NUM_IFS*NUM_DATA_BITS-1:0]   rx_data,
    input  logic [NUM_IFS-1:0]                 tx_valid,
    output logic [NUM_IFS-1:0]                 tx_ready,
    input  logic [NUM_IFS*NUM_DATA_BITS-1:0]   tx_data,
    input  logic [NUM_IFS-1:0]                 clear_flags,
    output logic [NUM_IFS-1:0]                 rx_overflow,
    output logic [NUM_IFS-1:0]                 tx_timeout
);
    localparam int W      = NUM_DATA_BITS;
    localparam int RX_CW  = clog2(RX_DEPTH) + 1;
    localparam int TX_CW  = clog2(TX_DEPTH) + 1;
    localparam int TO_W   = (DONE_TIMEOUT < 2) ? 1 : clog2(DONE_TIMEOUT);
    localparam bit WDOG_EN = (DONE_TIMEOUT > 0);

    genvar i;
    generate
        for (i = 0; i < NUM_IFS; i++) begin : g_ch
            logic [RX_CW-1:0] rx_count;
            logic             rx_empty;
            logic             rx_full;
            logic             rx_pop;
            logic             rx_ovf_set;
            logic             rx_ovf_q;

            logic [TX_CW-1:0] tx_count;
            logic             tx_empty;
            logic             tx_full;
            logic             tx_push;
            logic             tx_pop;
            logic [W-1:0]     tx_head;
            logic [1:0]       state;
            logic [TO_W-1:0]  wait_cnt;
            logic             done_hit;
            logic             timeout_hit;
            logic             tx_to_q;

            bus_sync_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
                .clk       (sys_clk),
                .rst       (rst),
                .push      (ctrl_recv_new_data[i]),
                .push_data (ctrl_recv_data[i*W +: W]),
                .pop       (rx_ready[i]),
                .head      (rx_data[i*W +: W]),
                .count     (rx_count)
            );

            assign rx_empty   = (rx_count == '0);
            assign rx_full    = (rx_count == RX_CW'(RX_DEPTH));
            assign rx_pop     = rx_ready[i] && !rx_empty;
            assign rx_ovf_set = ctrl_recv_new_data[i] && rx_full && !rx_pop;
            assign rx_valid[i] = !rx_empty;

            bus_sync_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
                .clk       (sys_clk),
                .rst       (rst),
                .push      (tx_push),
                .push_data (tx_data[i*W +: W]),
                .pop       (tx_pop),
                .head      (tx_head),
                .count     (tx_count)
            );

            assign tx_empty    = (tx_count == '0);
            assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
            assign tx_ready[i] = !tx_full;
            assign tx_push     = tx_valid[i] && !tx_full;

            // A done arriving on the expiry cycle wins over the watchdog.
            assign done_hit    = (state == SEQ_WAIT_DONE) && ctrl_send_done[i];
            assign timeout_hit = WDOG_EN && (state == SEQ_WAIT_DONE) && !ctrl_send_done[i]
                                 && (wait_cnt == TO_W'(DONE_TIMEOUT - 1));
            assign tx_pop      = done_hit || timeout_hit;

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    state    <= SEQ_IDLE;
                    wait_cnt <= '0;
                end else begin
                    case (state)
                        SEQ_IDLE: begin
                            if (!tx_empty && ctrl_send_ready[i]) state <= SEQ_START;
                        end
                        SEQ_START: begin
                            state    <= SEQ_WAIT_DONE;
                            wait_cnt <= '0;
                        end
                        SEQ_WAIT_DONE: begin
                            if (tx_pop) state <= SEQ_IDLE;
                            else        wait_cnt <= wait_cnt + TO_W'(1);
                        end
                        default: state <= SEQ_IDLE;
                    endcase
                end
            end

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    rx_ovf_q <= 1'b0;
                    tx_to_q  <= 1'b0;
                end else begin
                    if (rx_ovf_set)          rx_ovf_q <= 1'b1;
                    else if (clear_flags[i]) rx_ovf_q <= 1'b0;
                    if (timeout_hit)         tx_to_q  <= 1'b1;
                    else if (clear_flags[i]) tx_to_q  <= 1'b0;
                end
            end

            assign rx_overflow[i]          = rx_ovf_q;
            assign tx_timeout[i]           = tx_to_q;
            assign ctrl_send_start[i]      = (state == SEQ_START);
            assign ctrl_select[i]          = (state != SEQ_IDLE) || !tx_empty;
            assign ctrl_keep_alive[i]      = (state == SEQ_IDLE) ? !tx_empty
                                                                 : (tx_count >= TX_CW'(2));
            assign ctrl_send_data[i*W +: W] = tx_head;
        end
    endgenerate

endmodule

// File: tb/tb_buffered_bus_interface.sv
// tb/tb_buffered_bus_interface.sv - scoreboard bench for buffered_bus_interface
module tb_buffered_bus_interface;
    localparam int N = 2;
    localparam int W = 8;

    logic           sys_clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ctrl_recv_new_data, ctrl_send_ready, ctrl_send_done, ctrl_send_start;
    logic [N-1:0]   ctrl_select, ctrl_keep_alive, rx_valid, rx_ready, tx_valid, tx_ready;
    logic [N-1:0]   clear_flags, rx_overflow, tx_timeout;
    logic [N*W-1:0] ctrl_recv_data, ctrl_send_data, rx_data, tx_data;
    logic [N-1:0]   done_resp, done_stim, resp_en;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] rx_exp0 [$];
    logic [7:0] tx_exp0 [$];
    logic [7:0] tx_exp1 [$];
    int start_at [$];
    logic ka_at [$];
    int drop_at;
    int to_at;
    logic [7:0] burst [3] = '{8'h11, 8'h22, 8'h33};

    assign ctrl_send_done = done_resp | done_stim;

    buffered_bus_interface #(
        .NUM_IFS(N), .NUM_DATA_BITS(W), .RX_DEPTH(4), .TX_DEPTH(4), .DONE_TIMEOUT(10)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .ctrl_recv_new_data(ctrl_recv_new_data), .ctrl_recv_data(ctrl_recv_data),
        .ctrl_send_ready(ctrl_send_ready), .ctrl_send_done(ctrl_send_done),
        .ctrl_send_start(ctrl_send_start), .ctrl_select(ctrl_select),
        .ctrl_keep_alive(ctrl_keep_alive), .ctrl_send_data(ctrl_send_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .clear_flags(clear_flags), .rx_overflow(rx_overflow), .tx_timeout(tx_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_send_start"}, ctrl_send_start, 0);
        check({tag, "_select"}, ctrl_select, 0);
        check({tag, "_keep_alive"}, ctrl_keep_alive, 0);
        check({tag, "_send_data"}, ctrl_send_data, 0);
        check({tag, "_rx_overflow"}, rx_overflow, 0);
        check({tag, "_tx_timeout"}, tx_timeout, 0);
        check({tag, "_tx_ready"}, tx_ready, 2'b11);
    endtask

    // Monitor: pops expectations whenever the DUT hands out a word.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (rx_valid[0] && rx_ready[0]) begin
                    check("rx0_pop_expected", rx_exp0.size() != 0, 1);
                    if (rx_exp0.size() != 0) begin
                        e = rx_exp0.pop_front();
                        check("rx0_data", rx_data[7:0], e);
                    end
                end
                if (ctrl_send_start[0]) begin
                    check("tx0_start_expected", tx_exp0.size() != 0, 1);
                    check("tx0_select_at_start", ctrl_select[0], 1);
                    if (tx_exp0.size() != 0) begin
                        e = tx_exp0.pop_front();
                        check("tx0_send_data", ctrl_send_data[7:0], e);
                    end
                end
                if (ctrl_send_start[1]) begin
                    check("tx1_start_expected", tx_exp1.size() != 0, 1);
                    check("tx1_select_at_start", ctrl_select[1], 1);
                    if (tx_exp1.size() != 0) begin
                        e = tx_exp1.pop_front();
                        check("tx1_send_data", ctrl_send_data[15:8], e);
                    end
                end
            end
        end
    end

    // Controller model: send_done three cycles after each start on enabled channels.
    initial begin
        int cd [2];
        cd[0] = 0;
        cd[1] = 0;
        done_resp = '0;
        forever begin
            @(negedge sys_clk);
            for (int ch = 0; ch < 2; ch++)
                if (resp_en[ch] && ctrl_send_start[ch]) cd[ch] = 3;
            @(posedge sys_clk);
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                done_resp[ch] = 1'b0;
                if (cd[ch] > 0) begin
                    cd[ch]--;
                    if (cd[ch] == 0) done_resp[ch] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1;
        ctrl_recv_new_data = '0; ctrl_recv_data = '0; ctrl_send_ready = '0;
        rx_ready = '0; tx_valid = '0; tx_data = '0; clear_flags = '0;
        done_stim = '0; resp_en = '0;
        tick(); tick();
        @(negedge sys_clk);
        check_reset_outputs("reset");
        tick(); rst = 1'b0;

        // RX pass-through
        rx_ready[0] = 1'b1;
        tick(); ctrl_recv_new_data[0] = 1'b1; ctrl_recv_data[7:0] = 8'hA5; rx_exp0.push_back(8'hA5);
        @(negedge sys_clk); check("rx_valid_push_cycle", rx_valid[0], 0);
        tick(); ctrl_recv_data[7:0] = 8'h3C; rx_exp0.push_back(8'h3C);
        @(negedge sys_clk); check("rx_first_latency", rx_data[7:0], 8'hA5);
        tick(); ctrl_recv_new_data[0] = 1'b0;
        tick(); tick();
        @(negedge sys_clk);
        check("rx_passthru_empty", rx_valid[0], 0);
        check("rx_passthru_no_ovf", rx_overflow[0], 0);
        rx_ready[0] = 1'b0;

        // RX overflow
        for (int k = 1; k <= 5; k++) begin
            tick(); ctrl_recv_new_data[0] = 1'b1; ctrl_recv_data[7:0] = 8'(k);
            if (k <= 4) rx_exp0.push_back(8'(k));
        end
        tick(); ctrl_recv_new_data[0] = 1'b0;
        @(negedge sys_clk); check("rx_overflow_set", rx_overflow[0], 1);
        tick(); rx_ready[0] = 1'b1;
        repeat (4) tick();
        rx_ready[0] = 1'b0;
        @(negedge sys_clk); check("rx_overflow_drained", rx_valid[0], 0);
        tick(); clear_flags[0] = 1'b1;
        @(negedge sys_clk); check("rx_overflow_sticky", rx_overflow[0], 1);
        tick(); clear_flags[0] = 1'b0;
        @(negedge sys_clk); check("rx_overflow_cleared", rx_overflow[0], 0);

        // TX burst on ch1
        resp_en[1] = 1'b1; ctrl_send_ready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); tx_valid[1] = 1'b1; tx_data[15:8] = burst[k]; tx_exp1.push_back(burst[k]);
            @(negedge sys_clk); check("tx_start_latency", ctrl_send_start[1], k == 2);
        end
        tick(); tx_valid[1] = 1'b0;
        drop_at = -1;
        for (int c = 0; c < 40 && drop_at < 0; c++) begin
            @(negedge sys_clk);
            if (ctrl_send_start[1]) begin
                start_at.push_back(c);
                ka_at.push_back(ctrl_keep_alive[1]);
            end
            if (!ctrl_select[1]) drop_at = c;
        end
        check("tx_burst_select_drop", drop_at, 13);
        check("tx_burst_later_starts", start_at.size(), 2);
        if (start_at.size() == 2) begin
            check("tx_b2b_start_22", start_at[0], 4);
            check("tx_b2b_start_33", start_at[1], 9);
            check("tx_keep_alive_22", ka_at[0], 1);
            check("tx_keep_alive_33", ka_at[1], 0);
        end
        resp_en[1] = 1'b0; ctrl_send_ready[1] = 1'b0;

        // Watchdog, with clear_flags held to show set wins over clear
        tick(); ctrl_send_ready[0] = 1'b1; tx_valid[0] = 1'b1; tx_data[7:0] = 8'h7E;
        tx_exp0.push_back(8'h7E); clear_flags[0] = 1'b1;
        tick(); tx_valid[0] = 1'b0;
        to_at = -1;
        for (int c = 0; c < 40 && to_at < 0; c++) begin
            @(negedge sys_clk);
            if (tx_timeout[0]) to_at = c;
        end
        check("tx_timeout_cycle", to_at, 12);
        check("tx_timeout_select_idle", ctrl_select[0], 0);
        check("tx_timeout_tx_ready", tx_ready[0], 1);
        tick(); clear_flags[0] = 1'b0;
        @(negedge sys_clk); check("tx_timeout_cleared", tx_timeout[0], 0);

        // send_done on the expiry cycle is a normal completion
        tick(); tx_valid[0] = 1'b1; tx_data[7:0] = 8'h5A; tx_exp0.push_back(8'h5A);
        tick(); tx_valid[0] = 1'b0;
        repeat (11) tick();
        done_stim[0] = 1'b1;
        tick(); done_stim[0] = 1'b0;
        @(negedge sys_clk);
        check("done_at_expiry_no_timeout", tx_timeout[0], 0);
        check("done_at_expiry_idle", ctrl_select[0], 0);

        // Reset while waiting for send_done with two words queued behind the head
        tick(); tx_valid[0] = 1'b1; tx_data[7:0] = 8'hC1; tx_exp0.push_back(8'hC1);
        tick(); tx_data[7:0] = 8'hC2;
        tick(); tx_data[7:0] = 8'hC3;
        tick(); tx_valid[0] = 1'b0;
        @(negedge sys_clk); check("pre_reset_keep_alive", ctrl_keep_alive[0], 1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; ctrl_send_ready[0] = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("midreset");
        tick(); done_stim[0] = 1'b1;
        tick(); done_stim[0] = 1'b0;
        @(negedge sys_clk);
        check("stray_done_select", ctrl_select[0], 0);
        check("stray_done_start", ctrl_send_start[0], 0);
        check("stray_done_timeout", tx_timeout[0], 0);
        check("tx0_exp_drained", tx_exp0.size(), 0);

        // ch0 full RX with simultaneous push/pop while ch1 sends
        resp_en[1] = 1'b1; ctrl_send_ready[1] = 1'b1;
        tick(); tx_valid[1] = 1'b1; tx_data[15:8] = 8'h66; tx_exp1.push_back(8'h66);
        ctrl_recv_new_data[0] = 1'b1; ctrl_recv_data[7:0] = 8'h41; rx_exp0.push_back(8'h41);
        tick(); tx_data[15:8] = 8'h77; tx_exp1.push_back(8'h77);
        ctrl_recv_data[7:0] = 8'h42; rx_exp0.push_back(8'h42);
        tick(); tx_valid[1] = 1'b0; ctrl_recv_data[7:0] = 8'h43; rx_exp0.push_back(8'h43);
        tick(); ctrl_recv_data[7:0] = 8'h44; rx_exp0.push_back(8'h44);
        tick(); ctrl_recv_data[7:0] = 8'h45; rx_exp0.push_back(8'h45); rx_ready[0] = 1'b1;
        tick(); ctrl_recv_data[7:0] = 8'h46; rx_ready[0] = 1'b0;
        @(negedge sys_clk); check("simul_push_pop_no_ovf", rx_overflow[0], 0);
        tick(); ctrl_recv_new_data[0] = 1'b0;
        @(negedge sys_clk); check("simul_count_still_full", rx_overflow[0], 1);
        tick(); rx_ready[0] = 1'b1;
        repeat (4) tick();
        rx_ready[0] = 1'b0;
        @(negedge sys_clk); check("simul_rx_drained", rx_valid[0], 0);
        tick(); clear_flags[0] = 1'b1;
        tick(); clear_flags[0] = 1'b0;
        drop_at = -1;
        for (int c = 0; c < 40 && drop_at < 0; c++) begin
            @(negedge sys_clk);
            if (!ctrl_select[1]) drop_at = c;
        end
        check("ch1_sequence_finished", drop_at >= 0, 1);
        check("ch1_no_timeout", tx_timeout[1], 0);
        resp_en[1] = 1'b0; ctrl_send_ready[1] = 1'b0;

        tick(); tick();
        check("rx0_exp_empty", rx_exp0.size(), 0);
        check("tx0_exp_empty", tx_exp0.size(), 0);
        check("tx1_exp_empty", tx_exp1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/buffered_bus_interface.md
Name: buffered_bus_interface

Overview:
- Sits between a bus controller's generic handshake (recv_new_data / send_ready / send_start / send_done / select / keep_alive) and the MITM logic.
- Provides NUM_IFS independent channels. Each channel has an RX FIFO that captures real received words and a TX FIFO that queues fake words.
- A per-channel TX sequencer drains the TX FIFO into the controller.
- Decouples MITM processing latency from bus timing; adds overflow detection and a send-done watchdog.

Parameters:
- NUM_IFS, 2, number of bus interfaces/channels (>=1).
- NUM_DATA_BITS, 8, word width.
- RX_DEPTH, 4, RX FIFO depth per channel; power of 2, >=2.
- TX_DEPTH, 4, TX FIFO depth per channel; power of 2, >=2.
- DONE_TIMEOUT, 0, max sys_clk cycles waiting for send_done; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_recv_new_data  in  NUM_IFS  1-cycle pulse per channel: controller received a word.
- ctrl_recv_data  in  NUM_IFS*NUM_DATA_BITS  received words; channel i at bits [i*W +: W].
- ctrl_send_ready  in  NUM_IFS  controller can accept a fake send.
- ctrl_send_done  in  NUM_IFS  1-cycle pulse: fake send finished.
- ctrl_send_start  out  NUM_IFS  1-cycle start pulse to controller.
- ctrl_select  out  NUM_IFS  fake-path select to controller.
- ctrl_keep_alive  out  NUM_IFS  more queued words follow the current one.
- ctrl_send_data  out  NUM_IFS*NUM_DATA_BITS  word being sent.
- rx_valid  out  NUM_IFS  RX FIFO non-empty.
- rx_ready  in  NUM_IFS  logic pops RX head.
- rx_data  out  NUM_IFS*NUM_DATA_BITS  RX head, first-word fall-through.
- tx_valid  in  NUM_IFS  logic offers a word.
- tx_ready  out  NUM_IFS  TX FIFO not full.
- tx_data  in  NUM_IFS*NUM_DATA_BITS  word to queue.
- clear_flags  in  NUM_IFS  clears the sticky flags of that channel.
- rx_overflow  out  NUM_IFS  sticky: RX word dropped.
- tx_timeout  out  NUM_IFS  sticky: watchdog fired.

Behaviour:
- Reset (sync, rst=1 at a clock edge): all FIFOs empty, all sequencers IDLE, sticky flags 0. All outputs then read 0: rx_valid, rx_data, ctrl_send_start, ctrl_select, ctrl_keep_alive, ctrl_send_data, and both flags. tx_ready reads 1.
- Reset mid-transfer abandons any queued or in-flight word; no send_done is awaited.
- Channels are fully independent; there is no shared arbitration.

RX path, per channel i:
- A ctrl_recv_new_data pulse pushes the ctrl_recv_data slice.
- rx_valid rises the cycle after the push (1-cycle latency).
- A pop occurs when rx_valid && rx_ready; rx_data shows the new head the next cycle.
- Push while full with no pop: the word is dropped and rx_overflow sets. Existing contents are unchanged.
- Push and pop in the same cycle while full: both succeed, count is unchanged, no overflow.
- Push while empty: rx_ready is ignored that cycle, since rx_valid is still 0.

TX FIFO, per channel i:
- tx_ready = !full. A push occurs when tx_valid && tx_ready.
- tx_ready does not account for a pop in the same cycle.

TX sequencer states: IDLE, START, WAIT_DONE.
- IDLE: if the FIFO is non-empty and ctrl_send_ready=1, go to START.
- START: ctrl_send_start=1 for exactly this one cycle; ctrl_send_data = FIFO head. Then go to WAIT_DONE.
- WAIT_DONE: ctrl_send_data holds the head.
  - On ctrl_send_done: pop the head and go to IDLE.
  - If DONE_TIMEOUT>0 and the cycle counter reaches DONE_TIMEOUT first: pop (the word is discarded), set tx_timeout, go to IDLE.
  - send_done arriving in the same cycle the counter expires counts as done; no timeout is flagged.
  - The counter resets on entry to WAIT_DONE.
- ctrl_select = (state != IDLE) || FIFO non-empty.
- ctrl_keep_alive = 1 in IDLE when non-empty, and in START/WAIT_DONE when count >= 2.
- ctrl_send_start registered, 1 cycle wide. ctrl_send_data = 0 when in IDLE and empty.
- Minimum latency: tx push at cycle t -> ctrl_send_start high at cycle t+2, provided ctrl_send_ready=1.
- Back-to-back words: send_done at cycle u -> next ctrl_send_start at u+2.
- ctrl_send_done outside WAIT_DONE is ignored.

Sticky flags:
- Set has priority over clear_flags when both occur in the same cycle.
- clear_flags otherwise clears the flag the next cycle.

Decomposition:
- Shared package bus_if_pkg holds the sequencer state encoding (IDLE=0, START=1, WAIT_DONE=2) and the clog2 helper for the count and timeout-counter widths.
- Sub-module bus_sync_fifo (parametrised WIDTH, DEPTH; FWFT; count output with width clog2(DEPTH)+1).
- bus_sync_fifo is instantiated twice per channel in a generate loop over NUM_IFS. The sequencer stays inline in the top.

Test Plan:
- RX pass-through: ch0 recv pulses 0xA5 then 0x3C, rx_ready=1 -> rx_data 0xA5 a cycle after the first pulse, then 0x3C; no overflow.
- RX overflow, RX_DEPTH=4, rx_ready=0: 5 pulses 0x01..0x05 -> rx_overflow[0]=1; pops return 0x01..0x04. clear_flags[0] -> flag 0 next cycle.
- TX burst, ch1: push 0x11, 0x22, 0x33 with send_ready=1 and send_done 3 cycles after each start.
  - 3 start pulses; data 0x11, 0x22, 0x33; select held high throughout.
  - keep_alive drops during the 0x33 transfer; select=0 after the last done.
- Watchdog, DONE_TIMEOUT=10: push 0x7E, never assert send_done -> tx_timeout[0]=1 exactly 10 cycles after entering WAIT_DONE; FIFO empty; state IDLE.
- Reset mid-operation: rst during ch0 WAIT_DONE with 2 words queued -> next cycle all outputs at reset values, tx_ready=1; a later stray send_done is ignored.
- Channel independence and simultaneity: ch0 full-FIFO simultaneous push+pop with ch1 TX active -> ch0 count unchanged, no overflow; ch1 sequence unaffected.
